axi_rr_master_mux: RTL and testbench

- Shares one SoC AXI master port between two requesters (slv0, slv1). Both requesters and the shared port use the ariane_axi_soc::req_t / resp_t structs.
- The write path (AW/W/B) and the read path (AR/R) are arbitrated independently.
- Ownership is tenure-based. A requester keeps a path until it yields and all of its outstanding responses have returned. Response routing therefore needs no ID extension.
- Sits between the core/DMA request structs and the SoC crossbar master slot.

---
 rtl/axi_rr_master_mux.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_rr_master_mux.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_master_mux.sv
// Two-requester AXI master mux. Write path (AW/W/B) and read path (AR/R) are each
// owned by one requester per tenure, so responses route back without ID extension.

package ariane_axi_soc;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_rr_master_mux #(
  parameter int unsigned MaxTxns = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  ariane_axi_soc::req_t  slv0_req_i,
  output ariane_axi_soc::resp_t slv0_resp_o,
  input  ariane_axi_soc::req_t  slv1_req_i,
  output ariane_axi_soc::resp_t slv1_resp_o,
  output ariane_axi_soc::req_t  mst_req_o,
  input  ariane_axi_soc::resp_t mst_resp_i
);

  localparam int unsigned     CntW   = $clog2(MaxTxns + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);
  localparam int unsigned     PathW  = 0;
  localparam int unsigned     PathR  = 1;

  typedef enum logic {StIdle, StBusy} path_state_e;

  path_state_e     state_q [2];
  path_state_e     state_d [2];
  logic            owner_q [2];
  logic            owner_d [2];
  logic            last_q  [2];
  logic            last_d  [2];
  logic            stop_q  [2];
  logic            stop_d  [2];
  logic [CntW-1:0] cnt_q   [2];
  logic [CntW-1:0] cnt_d   [2];

  ariane_axi_soc::req_t  slv_req  [2];
  ariane_axi_soc::resp_t slv_resp [2];

  // Per path, indexed by requester: request valid (aw_valid or ar_valid).
  logic [1:0] req_valid [2];
  logic [1:0] mst_rdy, busy, gate, fwd, hs, dec;

  assign slv_req[0]  = slv0_req_i;
  assign slv_req[1]  = slv1_req_i;
  assign slv0_resp_o = slv_resp[0];
  assign slv1_resp_o = slv_resp[1];

  always_comb begin
    req_valid[PathW] = {slv_req[1].aw_valid, slv_req[0].aw_valid};
    req_valid[PathR] = {slv_req[1].ar_valid, slv_req[0].ar_valid};
    mst_rdy[PathW]   = mst_resp_i.aw_ready;
    mst_rdy[PathR]   = mst_resp_i.ar_ready;
    for (int p = 0; p < 2; p++) begin
      busy[p] = (state_q[p] == StBusy);
      gate[p] = busy[p] & ~stop_q[p] & (cnt_q[p] < MaxCnt);
      fwd[p]  = gate[p] & req_valid[p][owner_q[p]];
      hs[p]   = fwd[p] & mst_rdy[p];
    end
    dec[PathW] = busy[PathW] & mst_resp_i.b_valid & slv_req[owner_q[PathW]].b_ready;
    dec[PathR] = busy[PathR] & mst_resp_i.r_valid & mst_resp_i.r.last
               & slv_req[owner_q[PathR]].r_ready;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= StIdle;
        owner_q[p] <= 1'b0;
        last_q[p]  <= 1'b1;
        stop_q[p]  <= 1'b0;
        cnt_q[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        state_q[p] <= state_d[p];
        owner_q[p] <= owner_d[p];
        last_q[p]  <= last_d[p];
        stop_q[p]  <= stop_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      owner_d[p] = owner_q[p];
      last_d[p]  = last_q[p];
      stop_d[p]  = stop_q[p];
      cnt_d[p]   = cnt_q[p];
      if (hs[p] && !dec[p]) begin
        cnt_d[p] = cnt_q[p] + 1'b1;
      end else if (dec[p] && !hs[p] && cnt_q[p] != '0) begin
        cnt_d[p] = cnt_q[p] - 1'b1;
      end
      case (state_q[p])
        StIdle: begin
          if (|req_valid[p]) begin
            owner_d[p] = (&req_valid[p]) ? ~last_q[p] : req_valid[p][1];
            state_d[p] = StBusy;
          end
        end
        StBusy: begin
          // Only stop once the owner's pending request can no longer be withdrawn.
          if (req_valid[p][~owner_q[p]] && (hs[p] || !req_valid[p][owner_q[p]])) begin
            stop_d[p] = 1'b1;
          end
          if (stop_q[p] && cnt_d[p] == '0) begin
            state_d[p] = StIdle;
            last_d[p]  = owner_q[p];
            stop_d[p]  = 1'b0;
          end
        end
        default: state_d[p] = StIdle;
      endcase
    end
  end

  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw       = slv_req[owner_q[PathW]].aw;
    mst_req_o.w        = slv_req[owner_q[PathW]].w;
    mst_req_o.ar       = slv_req[owner_q[PathR]].ar;
    mst_req_o.aw_valid = fwd[PathW];
    mst_req_o.ar_valid = fwd[PathR];
    for (int s = 0; s < 2; s++) begin
      slv_resp[s]   = '0;
      slv_resp[s].b = mst_resp_i.b;
      slv_resp[s].r = mst_resp_i.r;
    end
    if (busy[PathW]) begin
      slv_resp[owner_q[PathW]].aw_ready = gate[PathW] & mst_resp_i.aw_ready;
      mst_req_o.w_valid                 = slv_req[owner_q[PathW]].w_valid;
      slv_resp[owner_q[PathW]].w_ready  = mst_resp_i.w_ready;
      mst_req_o.b_ready                 = slv_req[owner_q[PathW]].b_ready;
      slv_resp[owner_q[PathW]].b_valid  = mst_resp_i.b_valid;
    end
    if (busy[PathR]) begin
      slv_resp[owner_q[PathR]].ar_ready = gate[PathR] & mst_resp_i.ar_ready;
      mst_req_o.r_ready                 = slv_req[owner_q[PathR]].r_ready;
      slv_resp[owner_q[PathR]].r_valid  = mst_resp_i.r_valid;
    end
  end

  // A response with nothing outstanding means the downstream port broke protocol.
  dec_at_zero_w: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dec[PathW] && cnt_q[PathW] == '0));
  dec_at_zero_r: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dec[PathR] && cnt_q[PathR] == '0));

endmodule

// File: tb/tb_axi_rr_master_mux.sv
// Directed bench for axi_rr_master_mux: a cycle table for the basic write path plus
// hand sequences for read ties, outstanding limit, preemption, counter and reset.

module tb_axi_rr_master_mux;

  ariane_axi_soc::req_t  s0, s1, mreq;
  ariane_axi_soc::resp_t r0, r1, mresp;
  logic clk, rst_n;
  int   n_chk, n_err, n_hs;
  logic aw_pend;

  // stim = {s0.aw_valid, s1.aw_valid, s0.w_valid, aw_ready, w_ready, b_valid, s0.b_ready,
  //         s1.b_ready}; want = {mst aw_valid, s0 aw_ready, s1 aw_ready, mst w_valid,
  //         s0 w_ready, s0 b_valid, s1 b_valid, mst b_ready}
  typedef struct packed {
    logic [7:0] stim;
    logic [7:0] want;
  } vec_t;

  vec_t vecs [11];

  axi_rr_master_mux #(.MaxTxns(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv0_req_i (s0),
    .slv0_resp_o(r0),
    .slv1_req_i (s1),
    .slv1_resp_o(r1),
    .mst_req_o  (mreq),
    .mst_resp_i (mresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] vr();
    return {mreq.aw_valid, mreq.w_valid, mreq.b_ready, mreq.ar_valid, mreq.r_ready,
            r0.aw_ready, r0.w_ready, r0.ar_ready, r0.b_valid, r0.r_valid,
            r1.aw_ready, r1.w_ready, r1.ar_ready, r1.b_valid, r1.r_valid};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    s0    = '0;
    s1    = '0;
    mresp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(vr()), 64'd0);
    rst_n = 1'b1;
  endtask

  // An AW offered but not accepted must still be offered in the next cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_pend = 1'b0;
    end else begin
      if (aw_pend) begin
        n_chk++;
        if (!mreq.aw_valid) begin
          n_err++;
          $display("FAIL aw_valid_stable: got 0, expected 1");
        end
      end
      aw_pend = mreq.aw_valid && !mresp.aw_ready;
    end
  end

  initial begin
    n_chk   = 0;
    n_err   = 0;
    aw_pend = 1'b0;
    vecs[0]  = '{8'b10111000, 8'b00000000};
    vecs[1]  = '{8'b10111000, 8'b11011000};
    vecs[2]  = '{8'b00000110, 8'b00000101};
    vecs[3]  = '{8'b00000000, 8'b00000000};
    vecs[4]  = '{8'b10000000, 8'b10000000};
    vecs[5]  = '{8'b10010000, 8'b11000000};
    vecs[6]  = '{8'b01000110, 8'b00000101};
    vecs[7]  = '{8'b01010000, 8'b00000000};
    vecs[8]  = '{8'b01010000, 8'b00000000};
    vecs[9]  = '{8'b01111000, 8'b10100000};
    vecs[10] = '{8'b00000101, 8'b00000011};

    // Single write, owner retention, and handover to slv1 as a cycle table.
    do_reset();
    s0.aw.id = 4'd1;
    s1.aw.id = 4'd2;
    for (int i = 0; i < 11; i++) begin
      {s0.aw_valid, s1.aw_valid, s0.w_valid, mresp.aw_ready, mresp.w_ready,
       mresp.b_valid, s0.b_ready, s1.b_ready} = vecs[i].stim;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          64'({mreq.aw_valid, r0.aw_ready, r1.aw_ready, mreq.w_valid, r0.w_ready,
               r0.b_valid, r1.b_valid, mreq.b_ready}), 64'(vecs[i].want));
      step();
    end

    // Read tie: slv0 first, slv1 only after slv0's last R, second tie to slv1.
    do_reset();
    s0.ar_valid = 1'b1;
    s0.ar.id    = 4'd1;
    s1.ar_valid = 1'b1;
    s1.ar.id    = 4'd2;
    mresp.ar_ready = 1'b1;
    @(negedge clk);
    chk("r_tie_idle", 64'(mreq.ar_valid), 64'd0);
    step();
    @(negedge clk);
    chk("r_tie_grant0_valid", 64'(mreq.ar_valid), 64'd1);
    chk("r_tie_grant0_id", 64'(mreq.ar.id), 64'd1);
    chk("r_tie_ready", 64'({r0.ar_ready, r1.ar_ready}), 64'b10);
    step();
    s0.ar_valid = 1'b0;
    @(negedge clk);
    chk("r_stop_after_hs", 64'(mreq.ar_valid), 64'd0);
    step();
    s0.ar_valid   = 1'b1;
    s0.ar.id      = 4'd3;
    mresp.r_valid = 1'b1;
    mresp.r.last  = 1'b0;
    s0.r_ready    = 1'b1;
    s1.r_ready    = 1'b1;
    @(negedge clk);
    chk("r_beat_to_slv0", 64'({r0.r_valid, r1.r_valid}), 64'b10);
    chk("r_hold_slv1", 64'(mreq.ar_valid), 64'd0);
    step();
    mresp.r.last = 1'b1;
    @(negedge clk);
    chk("r_last_to_slv0", 64'({r0.r_valid, r1.r_valid, mreq.r_ready}), 64'b101);
    step();
    mresp.r_valid = 1'b0;
    mresp.r.last  = 1'b0;
    @(negedge clk);
    chk("r_idle_after_last", 64'(mreq.ar_valid), 64'd0);
    step();
    @(negedge clk);
    chk("r_tie2_valid", 64'(mreq.ar_valid), 64'd1);
    chk("r_tie2_id", 64'(mreq.ar.id), 64'd2);
    chk("r_tie2_ready", 64'({r0.ar_ready, r1.ar_ready}), 64'b01);

    // Outstanding limit: 8 accepted, 9th held until a B returns.
    do_reset();
    s0.aw_valid    = 1'b1;
    s0.aw.id       = 4'd1;
    mresp.aw_ready = 1'b1;
    n_hs = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (mreq.aw_valid && mresp.aw_ready) n_hs++;
      step();
    end
    chk("max_hs_count", 64'(n_hs), 64'd8);
    mresp.b_valid = 1'b1;
    s0.b_ready    = 1'b1;
    @(negedge clk);
    chk("max_masked", 64'({mreq.aw_valid, r0.aw_ready, r0.b_valid}), 64'b001);
    step();
    mresp.b_valid = 1'b0;
    @(negedge clk);
    chk("max_accept_after_b", 64'({mreq.aw_valid, r0.aw_ready}), 64'b11);
    step();

    // Preemption mid-stream: stalled AW is kept, then slv0 is stopped.
    do_reset();
    s0.aw_valid    = 1'b1;
    s0.aw.id       = 4'd5;
    s1.aw.id       = 4'd6;
    mresp.aw_ready = 1'b1;
    repeat (3) step();
    s1.aw_valid    = 1'b1;
    mresp.aw_ready = 1'b0;
    @(negedge clk);
    chk("pre_stall_valid", 64'(mreq.aw_valid), 64'd1);
    step();
    mresp.aw_ready = 1'b1;
    @(negedge clk);
    chk("pre_hs_after_stall", 64'({mreq.aw_valid, r0.aw_ready, r1.aw_ready}), 64'b110);
    step();
    @(negedge clk);
    chk("pre_slv0_stopped", 64'({mreq.aw_valid, r0.aw_ready}), 64'b00);
    step();
    mresp.b_valid = 1'b1;
    s0.b_ready    = 1'b1;
    s1.b_ready    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("pre_b%0d_route", i),
          64'({r0.b_valid, r1.b_valid, mreq.aw_valid}), 64'b100);
      step();
    end
    mresp.b_valid = 1'b0;
    @(negedge clk);
    chk("pre_idle", 64'(mreq.aw_valid), 64'd0);
    step();
    @(negedge clk);
    chk("pre_slv1_valid", 64'({mreq.aw_valid, r1.aw_ready, r0.aw_ready}), 64'b110);
    chk("pre_slv1_id", 64'(mreq.aw.id), 64'd6);
    step();

    // Simultaneous AW and B handshakes at cnt=3.
    do_reset();
    s0.aw_valid    = 1'b1;
    mresp.aw_ready = 1'b1;
    repeat (4) step();
    mresp.b_valid = 1'b1;
    s0.b_ready    = 1'b1;
    @(negedge clk);
    chk("sim_both_hs", 64'({mreq.aw_valid, r0.b_valid, mreq.b_ready}), 64'b111);
    step();
    s0.aw_valid   = 1'b0;
    mresp.b_valid = 1'b0;
    @(negedge clk);
    chk("sim_cnt", 64'(dut.cnt_q[0]), 64'd3);
    chk("sim_state_busy", 64'(dut.state_q[0]), 64'd1);
    step();
    s0.aw_valid = 1'b1;
    @(negedge clk);
    chk("sim_still_owner", 64'({mreq.aw_valid, r0.aw_ready}), 64'b11);
    step();

    // Asynchronous reset while BUSY with cnt=2.
    do_reset();
    s0.aw_valid    = 1'b1;
    mresp.aw_ready = 1'b1;
    repeat (3) step();
    s0.aw_valid   = 1'b0;
    s0.w_valid    = 1'b1;
    s0.b_ready    = 1'b1;
    mresp.w_ready = 1'b1;
    mresp.b_valid = 1'b1;
    @(negedge clk);
    chk("rst_pre_cnt", 64'(dut.cnt_q[0]), 64'd2);
    chk("rst_pre_active", 64'({r0.b_valid, mreq.w_valid}), 64'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 64'(vr()), 64'd0);
    chk("rst_async_cnt", 64'(dut.cnt_q[0]), 64'd0);
    s0    = '0;
    s1    = '0;
    mresp = '0;
    step();
    rst_n = 1'b1;
    chk("rst_state_idle", 64'(dut.state_q[0]), 64'd0);
    s0.aw_valid    = 1'b1;
    s0.aw.id       = 4'd7;
    s1.aw_valid    = 1'b1;
    s1.aw.id       = 4'd8;
    mresp.aw_ready = 1'b1;
    step();
    @(negedge clk);
    chk("rst_tie_id", 64'(mreq.aw.id), 64'd7);
    chk("rst_tie_ready", 64'({r0.aw_ready, r1.aw_ready}), 64'b10);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
